// File: rtl/lsu_if.sv
// lsu_if: data-memory req/ack bus between the load/store unit (master) and memory (slave).
interface lsu_if #(parameter int XLEN = 32);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, input mem_ack, mem_rdata);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu.sv
// lsu: one data-memory transaction per request with lane steering, load extension
// and trap reporting for misaligned/illegal accesses.
module lsu #(parameter int XLEN = 32) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_is_store,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [4:0]      i_rd,
    lsu_if.master           mem,
    output logic            o_done,
    output logic            o_wb_we,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_exc,
    output logic [3:0]      o_exc_cause,
    output logic [XLEN-1:0] o_exc_addr
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state_q, state_d;
    logic            req_q, req_d, we_q, we_d, done_q, done_d, wb_we_q, wb_we_d, exc_q, exc_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d, exc_addr_q, exc_addr_d;
    logic [3:0]      wstrb_q, wstrb_d, cause_q, cause_d;
    logic [4:0]      rd_q, rd_d, wb_rd_q, wb_rd_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic            illegal, misal;
    logic [XLEN-1:0] st_data, ld_data;
    logic [3:0]      st_strb;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    assign o_ready = state_q == IDLE;
    assign illegal = i_is_store ? i_funct3 > 3'd2 : (i_funct3 == 3'd3 || i_funct3 > 3'd5);
    assign misal   = (i_funct3[1:0] == 2'd1 && i_addr[0]) || (i_funct3[1:0] == 2'd2 && i_addr[1:0] != 2'd0);
    assign st_data = i_funct3[1] ? i_store_data : i_funct3[0] ? {2{i_store_data[15:0]}} : {4{i_store_data[7:0]}};
    assign st_strb = i_funct3[1] ? 4'hf : i_funct3[0] ? (i_addr[1] ? 4'hc : 4'h3) : 4'b0001 << i_addr[1:0];
    assign ld_byte = mem.mem_rdata[{off_q, 3'b000} +: 8];
    assign ld_half = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    // funct3[2] selects the unsigned variants, so it suppresses the sign bit
    assign ld_data = f3_q[1] ? mem.mem_rdata
                   : f3_q[0] ? {{(XLEN-16){ld_half[15] & ~f3_q[2]}}, ld_half}
                   : {{(XLEN-8){ld_byte[7] & ~f3_q[2]}}, ld_byte};

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rd_d       = rd_q;
        f3_d       = f3_q;
        off_d      = off_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        exc_d      = exc_q;
        cause_d    = cause_q;
        exc_addr_d = exc_addr_q;
        done_d     = 1'b0;
        wb_we_d    = 1'b0;
        case (state_q)
            IDLE: if (i_valid) begin
                rd_d  = i_rd;
                f3_d  = i_funct3;
                off_d = i_addr[1:0];
                if (illegal || misal) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    exc_d      = 1'b1;
                    cause_d    = illegal ? 4'd2 : i_is_store ? 4'd6 : 4'd4;
                    exc_addr_d = i_addr;
                    wb_rd_d    = i_rd;
                end else begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = i_is_store;
                    addr_d  = {i_addr[XLEN-1:2], 2'b00};
                    wdata_d = i_is_store ? st_data : '0;
                    wstrb_d = i_is_store ? st_strb : 4'h0;
                end
            end
            REQ: if (mem.mem_ack) begin
                state_d   = DONE;
                req_d     = 1'b0;
                done_d    = 1'b1;
                exc_d     = 1'b0;
                wb_we_d   = ~we_q;
                wb_rd_d   = rd_q;
                wb_data_d = we_q ? wb_data_q : ld_data;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rd_q       <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            exc_q      <= 1'b0;
            cause_q    <= '0;
            exc_addr_q <= '0;
            done_q     <= 1'b0;
            wb_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            exc_q      <= exc_d;
            cause_q    <= cause_d;
            exc_addr_q <= exc_addr_d;
            done_q     <= done_d;
            wb_we_q    <= wb_we_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;
    assign o_done        = done_q;
    assign o_wb_we       = wb_we_q;
    assign o_wb_rd       = wb_rd_q;
    assign o_wb_data     = wb_data_q;
    assign o_exc         = exc_q;
    assign o_exc_cause   = cause_q;
    assign o_exc_addr    = exc_addr_q;
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed vector table plus hand-written back-to-back and reset-mid-request sequences.
module tb_lsu;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid = 1'b0, is_store = 1'b0, ready, done, wb_we, exc;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, sdata = '0, wb_data, exc_addr;
    logic [4:0]  rd = '0, wb_rd;
    logic [3:0]  cause;
    int          total = 0, passed = 0;

    lsu_if #(.XLEN(32)) bus();

    lsu #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
        .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr), .i_store_data(sdata), .i_rd(rd),
        .mem(bus),
        .o_done(done), .o_wb_we(wb_we), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
        .o_exc(exc), .o_exc_cause(cause), .o_exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          wt;
        logic        exc;
        logic [3:0]  cause;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] wbd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v);
        logic [31:0] prev_wbd;
        prev_wbd = wb_data;
        chk("ready_idle", ready, 1);
        valid = 1'b1; is_store = v.st; funct3 = v.f3; addr = v.a; sdata = v.d; rd = v.rd;
        tick();
        valid = 1'b0;
        if (v.exc) begin
            chk("trap_done", done, 1);
            chk("trap_exc", exc, 1);
            chk("trap_cause", cause, v.cause);
            chk("trap_addr", exc_addr, v.a);
            chk("trap_noreq", bus.mem_req, 0);
            chk("trap_wbwe", wb_we, 0);
            chk("trap_wbdata_hold", wb_data, prev_wbd);
        end else begin
            for (int i = 0; i < v.wt; i++) begin
                chk("req_wait", bus.mem_req, 1);
                tick();
            end
            chk("req", bus.mem_req, 1);
            chk("we", bus.mem_we, v.st);
            chk("maddr", bus.mem_addr, {v.a[31:2], 2'b00});
            chk("wstrb", bus.mem_wstrb, v.strb);
            if (v.st) chk("wdata", bus.mem_wdata, v.wdata);
            bus.mem_ack = 1'b1; bus.mem_rdata = v.rdata;
            tick();
            bus.mem_ack = 1'b0; bus.mem_rdata = 32'h5a5a5a5a;
            chk("done", done, 1);
            chk("req_drop", bus.mem_req, 0);
            chk("exc_clear", exc, 0);
            chk("wb_we", wb_we, !v.st);
            chk("wb_data", wb_data, v.st ? prev_wbd : v.wbd);
            if (!v.st) chk("wb_rd", wb_rd, v.rd);
        end
        tick();
        chk("done_pulse", done, 0);
        chk("ready_back", ready, 1);
        chk("wb_data_hold", wb_data, v.exc ? prev_wbd : v.st ? prev_wbd : v.wbd);
    endtask

    initial begin
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        //           st f3     addr          data          rdata         rd  wt exc cause strb   wdata         wb_data
        vecs[0]  = '{1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        5'd1, 3, 0, 4'd0, 4'hf, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{0, 3'd0, 32'h103, 32'h0,        32'h80FF0000, 5'd5, 0, 0, 4'd0, 4'h0, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{0, 3'd4, 32'h103, 32'h0,        32'h80FF0000, 5'd7, 1, 0, 4'd0, 4'h0, 32'h0,        32'h00000080};
        vecs[3]  = '{1, 3'd1, 32'h202, 32'h1234ABCD, 32'h0,        5'd2, 0, 0, 4'd0, 4'hc, 32'hABCDABCD, 32'h0};
        vecs[4]  = '{0, 3'd2, 32'h101, 32'h0,        32'h0,        5'd9, 0, 1, 4'd4, 4'h0, 32'h0,        32'h0};
        vecs[5]  = '{1, 3'd1, 32'h3,   32'h0,        32'h0,        5'd9, 0, 1, 4'd6, 4'h0, 32'h0,        32'h0};
        vecs[6]  = '{1, 3'd4, 32'h10,  32'h0,        32'h0,        5'd9, 0, 1, 4'd2, 4'h0, 32'h0,        32'h0};
        vecs[7]  = '{0, 3'd1, 32'h206, 32'h0,        32'h80017FFF, 5'd11, 0, 0, 4'd0, 4'h0, 32'h0,       32'hFFFF8001};
        vecs[8]  = '{0, 3'd5, 32'h206, 32'h0,        32'h80017FFF, 5'd12, 2, 0, 4'd0, 4'h0, 32'h0,       32'h00008001};
        vecs[9]  = '{0, 3'd2, 32'h208, 32'h0,        32'h12345678, 5'd13, 1, 0, 4'd0, 4'h0, 32'h0,       32'h12345678};
        vecs[10] = '{1, 3'd0, 32'h41,  32'h000000A5, 32'h0,        5'd3, 0, 0, 4'd0, 4'h2, 32'hA5A5A5A5, 32'h0};
        vecs[11] = '{0, 3'd3, 32'h20,  32'h0,        32'h0,        5'd4, 0, 1, 4'd2, 4'h0, 32'h0,        32'h0};
        vecs[12] = '{0, 3'd6, 32'h24,  32'h0,        32'h0,        5'd4, 0, 1, 4'd2, 4'h0, 32'h0,        32'h0};
        vecs[13] = '{0, 3'd0, 32'h100, 32'h0,        32'h0000007F, 5'd31, 0, 0, 4'd0, 4'h0, 32'h0,       32'h0000007F};

        #12;
        chk("rst_ready", ready, 1);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_strb", bus.mem_wstrb, 0);
        chk("rst_maddr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_outs", {done, wb_we, exc, cause, wb_rd}, 0);
        chk("rst_wbdata", wb_data, 0);
        chk("rst_excaddr", exc_addr, 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[k]) run(vecs[k]);

        // back-to-back: valid held, ack held high throughout (stray in IDLE/DONE)
        valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h300; rd = 5'd3;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11112222;
        chk("b2b_acc1", ready, 1);
        tick();
        chk("b2b_req1", bus.mem_req, 1);
        chk("b2b_busy1", ready, 0);
        tick();
        chk("b2b_done1", done, 1);
        chk("b2b_data1", wb_data, 32'h11112222);
        chk("b2b_rd1", wb_rd, 3);
        chk("b2b_busy_done", ready, 0);
        funct3 = 3'd4; addr = 32'h301; rd = 5'd4;
        tick();
        chk("b2b_idle", {ready, done, bus.mem_req}, 3'b100);
        bus.mem_rdata = 32'h0000AB00;
        tick();
        chk("b2b_req2", bus.mem_req, 1);
        chk("b2b_addr2", bus.mem_addr, 32'h300);
        tick();
        valid = 1'b0;
        chk("b2b_done2", done, 1);
        chk("b2b_data2", wb_data, 32'h000000AB);
        chk("b2b_rd2", wb_rd, 4);
        tick();
        tick();
        chk("b2b_stray_ack", {ready, done, bus.mem_req}, 3'b100);
        chk("b2b_hold", wb_data, 32'h000000AB);
        bus.mem_ack = 1'b0;

        // reset in the middle of a request
        valid = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h400; sdata = 32'hCAFEF00D;
        tick();
        valid = 1'b0;
        chk("rstm_req", bus.mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_req_drop", bus.mem_req, 0);
        chk("rstm_ready", ready, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        tick();
        bus.mem_ack = 1'b0;
        chk("rstm_no_done", {done, bus.mem_req, ready}, 3'b001);
        tick();
        chk("rstm_no_done2", {done, wb_we, exc}, 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I_Zicsr core. It sits directly downstream of the ALU and takes the ALU result as the effective address. It runs one data-memory transaction per request over a req/ack bus, handles byte-lane steering, write strobes and load sign/zero extension, and reports misaligned or illegal accesses instead of issuing them. Results go to writeback as a single-cycle completion pulse.

## Interface
- XLEN, 32, data/address width; only 32 is supported.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  execute stage presents a memory op; accepted only when o_ready=1.
- o_ready  out  1  LSU idle and able to accept.
- i_is_store  in  1  1=store, 0=load.
- i_funct3  in  3  RV32I width/sign code: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- i_addr  in  XLEN  effective address (ALU ADD result).
- i_store_data  in  XLEN  rs2 value.
- i_rd  in  5  destination register for loads.
- o_mem_req  out  1  bus request, held until ack.
- o_mem_we  out  1  1=write.
- o_mem_addr  out  XLEN  word address, {i_addr[31:2],2'b00}.
- o_mem_wdata  out  XLEN  lane-replicated store data.
- o_mem_wstrb  out  4  byte enables; 0 for loads.
- i_mem_ack  in  1  bus completes transaction this cycle.
- i_mem_rdata  in  XLEN  read word; valid when i_mem_ack=1.
- o_done  out  1  one-cycle completion pulse.
- o_wb_we  out  1  with o_done: write o_wb_data to o_wb_rd.
- o_wb_rd  out  5  latched i_rd.
- o_wb_data  out  XLEN  extended load result.
- o_exc  out  1  with o_done: access trapped, no bus activity.
- o_exc_cause  out  4  2=illegal funct3, 4=load misaligned, 6=store misaligned.
- o_exc_addr  out  XLEN  faulting i_addr, unmodified.

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- IDLE: o_ready=1. If i_valid=1, latch all inputs.
  - Illegal funct3 (load 3/6/7, store 3–7) goes to DONE with cause 2.
  - Misalignment (H with addr[0]=1, W with addr[1:0]≠0) goes to DONE with cause 4 or 6.
  - Otherwise go to REQ.
- REQ: o_mem_req=1; address, we, wdata and wstrb are stable for the whole request. When i_mem_ack=1, capture and extend rdata, then go to DONE.
- DONE: drive o_done=1 for exactly one cycle.
  - o_wb_we=1 only for a load with no exception.
  - o_exc=1 only when an exception was detected.
  - Return to IDLE.
- Store steering:
  - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata=d, wstrb=4'b1111.
- Load extraction:
  - Byte lane is addr[1:0]; halfword lane is addr[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word through.
- i_mem_ack outside REQ is ignored.
- i_valid while o_ready=0 is ignored; upstream must hold the request.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, o_ready=1.
  - All of these are 0: o_mem_req, o_mem_we, o_mem_wstrb, o_mem_addr, o_mem_wdata, o_done, o_wb_we, o_exc, o_exc_cause, o_wb_rd, o_wb_data, o_exc_addr.
- o_ready is combinational from state.
- All other outputs are registered.
- Normal access: accept in cycle N; o_mem_req high from N+1 until the ack cycle M ≥ N+1; o_done in cycle M+1.
- Minimum latency is 2 cycles from accept to o_done. Throughput is at most one op per 3 cycles.
- Trapped access: accept in N, o_done+o_exc in N+1, with o_mem_req never asserted.
- o_wb_data, o_wb_rd and o_exc_* hold their values after o_done until the next completion.
- Reset asserted mid-REQ: o_mem_req drops asynchronously, no o_done is produced, and a late ack after reset release is ignored.

## Test plan
- SW: addr=0x100, data=0xDEADBEEF, ack after 3 wait cycles -> o_mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; req held 3 cycles then through the ack cycle; o_done with o_wb_we=0.
- LB/LBU: addr=0x103, rdata=0x80FF_0000 -> LB gives o_wb_data=0xFFFFFF80; LBU gives 0x00000080; o_wb_rd equals i_rd.
- SH: addr=0x202, data=0x1234ABCD -> wdata=0xABCDABCD, wstrb=1100.
- Misaligned and illegal:
  - LW at addr=0x101 -> o_exc=1, cause=4, exc_addr=0x101, no o_mem_req, o_done one cycle after accept.
  - SH at addr=0x3 -> cause=6.
  - Store with funct3=4 -> cause=2.
- Back-to-back: i_valid held continuously across two loads with ack on the first REQ cycle -> each completes in exactly 2 cycles; the second is accepted only in the IDLE cycle after DONE; stray acks in IDLE have no effect.
- Reset mid-request: drop i_rst_n while in REQ -> o_mem_req=0 immediately, o_ready=1 after release, and an ack pulse after release produces no o_done.
